// File: rtl/key_driver.sv
// Key driver: walks candidate keys 0..MAX_KEY that agree with the latched care mask/value,
// presents each matching one to the lock for a cycle and stops on unlock or exhaustion.
module key_driver #(
    parameter logic [7:0] MAX_KEY = 8'hFF,
    parameter int         WARMUP  = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] care_mask,
    input  logic [7:0] care_value,
    input  logic       unlock,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [8:0] attempts
);

    localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);

    typedef enum logic [2:0] {IDLE, SEARCH, CHECK, DONE, FAIL} state_t;

    state_t          state;
    logic [7:0]      cnt;
    logic [7:0]      lat_mask;
    logic [7:0]      lat_value;
    logic [WW-1:0]   warm;
    logic [WW-1:0]   warm_next;
    logic            warm_sat;
    logic            cnt_match;

    always_comb begin
        warm_next = warm;
        if (warm != WARM_MAX)
            warm_next = warm + 1'b1;
    end

    // ready is registered, so it has to be computed from the post-edge warm-up count
    assign warm_sat  = (warm_next == WARM_MAX);
    assign cnt_match = ((cnt & lat_mask) == (lat_value & lat_mask));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= 8'h00;
            lat_mask  <= 8'h00;
            lat_value <= 8'h00;
            warm      <= '0;
            key       <= 8'h00;
            key_valid <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            attempts  <= 9'd0;
        end else begin
            warm <= warm_next;
            case (state)
                IDLE, DONE, FAIL: begin
                    key_valid <= 1'b0;
                    ready     <= warm_sat;
                    if (start && ready) begin
                        lat_mask  <= care_mask;
                        lat_value <= care_value;
                        cnt       <= 8'h00;
                        attempts  <= 9'd0;
                        fail      <= 1'b0;
                        if (unlock) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= SEARCH;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                            ready <= 1'b0;
                        end
                    end
                end
                SEARCH: begin
                    if (cnt_match) begin
                        key       <= cnt;
                        key_valid <= 1'b1;
                        attempts  <= attempts + 9'd1;
                        state     <= CHECK;
                    end else begin
                        key_valid <= 1'b0;
                        if (cnt == MAX_KEY) begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                            ready <= warm_sat;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                CHECK: begin
                    // key keeps its value here so the lock sees a stable candidate
                    key_valid <= 1'b0;
                    if (unlock) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ready <= warm_sat;
                    end else if (cnt == MAX_KEY) begin
                        state <= FAIL;
                        busy  <= 1'b0;
                        fail  <= 1'b1;
                        ready <= warm_sat;
                    end else begin
                        cnt   <= cnt + 8'd1;
                        state <= SEARCH;
                    end
                end
                default: begin
                    state     <= IDLE;
                    key_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    fail      <= 1'b0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule
